cordic_sincos: RTL and testbench

- Parametrised iterative CORDIC rotator: returns both sine and cosine of an unsigned fixed-point phase angle.
- Accepts any angle in [0, 4π); out-of-range angles are flagged as an error.
- Valid/ready handshakes on input and output.
- Sits between the phase accumulator and the waveform/mixer datapath, replacing the single-output sine-only unit.

---
 rtl/cordic_pkg.sv | 31 +++
 rtl/cordic_fold.sv | 46 ++++
 rtl/cordic_sincos.sv | 160 ++++++++++++++++
 tb/tb_cordic_sincos.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and constant-generation helpers for the
// iterative CORDIC sine/cosine rotator.
package cordic_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FOLD, ST_ITER, ST_HOLD} cordic_state_t;

  localparam int  ATAN_N = 24;
  localparam int  TAB_W  = 32;
  localparam real PI_R   = 3.14159265358979323846;

  typedef logic [ATAN_N-1:0][TAB_W-1:0] atan_tab_t;

  function automatic int pi2_calc(input int frac);
    return $rtoi(PI_R / 2.0 * (2.0 ** frac) + 0.5);
  endfunction

  localparam int PI2 = pi2_calc(16);

  function automatic int kinit_calc(input int ifrac);
    return $rtoi(0.6072529350088813 * (2.0 ** ifrac) + 0.5);
  endfunction

  function automatic atan_tab_t atan_table(input int frac);
    atan_tab_t t;
    for (int i = 0; i < ATAN_N; i++) begin
      t[i] = TAB_W'($rtoi($atan(2.0 ** (-i)) * (2.0 ** frac) + 0.5));
    end
    return t;
  endfunction

endpackage

// File: rtl/cordic_fold.sv
// Wraps an angle in [0, 4*PI2*2) down by one turn, flags angles still out of
// range, and folds the result into the first quadrant.
module cordic_fold
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = 20,
  parameter int FRAC    = 16
) (
  input  logic [ANGLE_W-1:0]      i_angle,
  output logic signed [ANGLE_W:0] o_z,
  output logic [1:0]              o_quad,
  output logic                    o_err
);

  localparam int AW = ANGLE_W + 3;
  localparam logic [AW-1:0] P1 = AW'(pi2_calc(FRAC));
  localparam logic [AW-1:0] P2 = AW'(2 * pi2_calc(FRAC));
  localparam logic [AW-1:0] P3 = AW'(3 * pi2_calc(FRAC));
  localparam logic [AW-1:0] P4 = AW'(4 * pi2_calc(FRAC));

  logic [AW-1:0] w_a;
  logic [AW-1:0] w_wrap;
  logic [AW-1:0] w_z;

  always_comb begin
    w_a    = AW'(i_angle);
    w_wrap = (w_a >= P4) ? (w_a - P4) : w_a;
    o_err  = (w_wrap >= P4);
    if (w_wrap < P1) begin
      o_quad = 2'd0;
      w_z    = w_wrap;
    end else if (w_wrap < P2) begin
      o_quad = 2'd1;
      w_z    = P2 - w_wrap;
    end else if (w_wrap < P3) begin
      o_quad = 2'd2;
      w_z    = w_wrap - P2;
    end else begin
      // An out-of-range angle lands here too; its z is meaningless but unused.
      o_quad = 2'd3;
      w_z    = P4 - w_wrap;
    end
    o_z = signed'((ANGLE_W + 1)'(w_z));
  end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC rotator producing sine and cosine of an unsigned phase.
// Define CORDIC_ROUND_EN to round (instead of truncate) the final >>>2 scaling.
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = 20,
  parameter int FRAC    = 16,
  parameter int OUT_W   = 16,
  parameter int ITER    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [ANGLE_W-1:0] i_in_angle,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [OUT_W-1:0]   o_out_sin,
  output logic [OUT_W-1:0]   o_out_cos,
  output logic               o_out_err
);

  localparam int XW = OUT_W + 4;
  localparam int IF = OUT_W + 1;
  localparam int SW = XW + 1;
  localparam int ZW = ANGLE_W + 1;
  localparam int CW = $clog2(ITER + 1);

  localparam atan_tab_t              ATAN  = atan_table(FRAC);
  localparam logic signed [XW-1:0]    KINIT = XW'(kinit_calc(IF));
  localparam logic signed [OUT_W-1:0] OMAX  = OUT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0]    SMAX  = SW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0]    SMIN  = -SMAX;

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SMAX) begin
      return OMAX;
    end else if (v < SMIN) begin
      return -OMAX;
    end else begin
      return OUT_W'(v);
    end
  endfunction

  cordic_state_t            r_state;
  logic [ANGLE_W-1:0]       r_angle;
  logic signed [ZW-1:0]     r_z;
  logic [1:0]               r_quad;
  logic                     r_err;
  logic signed [XW-1:0]     r_x;
  logic signed [XW-1:0]     r_y;
  logic [CW-1:0]            r_ctr;
  logic signed [OUT_W-1:0]  r_sin;
  logic signed [OUT_W-1:0]  r_cos;
  logic                     r_out_err;

  logic signed [ZW-1:0]     w_fz;
  logic [1:0]               w_fquad;
  logic                     w_ferr;
  logic signed [XW-1:0]     w_xs;
  logic signed [XW-1:0]     w_ys;
  logic signed [ZW-1:0]     w_atan;
  logic signed [SW-1:0]     w_xr;
  logic signed [SW-1:0]     w_yr;
  logic signed [OUT_W-1:0]  w_sin_m;
  logic signed [OUT_W-1:0]  w_cos_m;
  logic signed [OUT_W-1:0]  w_sin;
  logic signed [OUT_W-1:0]  w_cos;

  cordic_fold #(.ANGLE_W(ANGLE_W), .FRAC(FRAC)) u_fold (
    .i_angle (r_angle),
    .o_z     (w_fz),
    .o_quad  (w_fquad),
    .o_err   (w_ferr)
  );

  always_comb begin
    w_xs   = r_x >>> r_ctr;
    w_ys   = r_y >>> r_ctr;
    w_atan = signed'(ZW'(ATAN[r_ctr]));
`ifdef CORDIC_ROUND_EN
    w_xr = (SW'(r_x) + SW'(2)) >>> 2;
    w_yr = (SW'(r_y) + SW'(2)) >>> 2;
`else
    w_xr = SW'(r_x) >>> 2;
    w_yr = SW'(r_y) >>> 2;
`endif
    w_cos_m = sat(w_xr);
    w_sin_m = sat(w_yr);
    // Undo the quadrant fold: sin flips in q2/q3, cos flips in q1/q2.
    w_sin = r_quad[1] ? -w_sin_m : w_sin_m;
    w_cos = (r_quad[1] ^ r_quad[0]) ? -w_cos_m : w_cos_m;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_angle   <= '0;
      r_z       <= '0;
      r_quad    <= 2'd0;
      r_err     <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_ctr     <= '0;
      r_sin     <= '0;
      r_cos     <= '0;
      r_out_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_angle <= i_in_angle;
            r_state <= ST_FOLD;
          end
        end
        ST_FOLD: begin
          r_z     <= w_fz;
          r_quad  <= w_fquad;
          r_err   <= w_ferr;
          r_x     <= KINIT;
          r_y     <= '0;
          r_ctr   <= '0;
          r_state <= ST_ITER;
        end
        ST_ITER: begin
          if (r_ctr == CW'(ITER)) begin
            r_sin     <= r_err ? '0 : w_sin;
            r_cos     <= r_err ? '0 : w_cos;
            r_out_err <= r_err;
            r_state   <= ST_HOLD;
          end else begin
            if (!r_z[ZW-1]) begin
              r_x <= r_x - w_ys;
              r_y <= r_y + w_xs;
              r_z <= r_z - w_atan;
            end else begin
              r_x <= r_x + w_ys;
              r_y <= r_y - w_xs;
              r_z <= r_z + w_atan;
            end
            r_ctr <= r_ctr + CW'(1);
          end
        end
        ST_HOLD: begin
          if (i_out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_out_valid = (r_state == ST_HOLD);
  assign o_out_sin   = r_sin;
  assign o_out_cos   = r_cos;
  assign o_out_err   = r_out_err;

endmodule

// File: tb/tb_cordic_sincos.sv
// Scoreboard bench for cordic_sincos: expectations from a real-arithmetic
// sin/cos model are queued at acceptance and checked by an output monitor.
module tb_cordic_sincos;

  localparam int ITER = 16;
  localparam int LAT  = ITER + 2;
  localparam int PI2  = 102944;
`ifdef CORDIC_ROUND_EN
  localparam int TOL = 2;
`else
  localparam int TOL = 3;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [19:0]        in_angle;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_sin;
  logic signed [15:0] out_cos;
  logic               out_err;

  typedef struct {
    int s;
    int c;
    bit e;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   last_hs = -100;
  logic prev_valid = 1'b0;

  cordic_sincos #(.ANGLE_W(20), .FRAC(16), .OUT_W(16), .ITER(ITER)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_angle  (in_angle),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_sin   (out_sin),
    .o_out_cos   (out_cos),
    .o_out_err   (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int rnd_sat(input real x);
    int v;
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    if (v > 32767) v = 32767;
    if (v < -32767) v = -32767;
    return v;
  endfunction

  // Reference: angle taken modulo one 4*PI2 turn, sin/cos from real math.
  function automatic void model(input int a, output int s, output int c, output bit e);
    int  w;
    real r;
    w = a;
    if (w >= 4 * PI2) w = w - 4 * PI2;
    e = (w >= 4 * PI2);
    if (e) begin
      s = 0;
      c = 0;
    end else begin
      r = real'(w) / 65536.0;
      s = rnd_sat($sin(r) * 32768.0);
      c = rnd_sat($cos(r) * 32768.0);
    end
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Output monitor: latency on each rising out_valid, values on each handshake.
  always @(negedge clk) begin
    exp_t x;
    if (!reset && out_valid && !prev_valid) begin
      if (exp_q.size() == 0) check(1'b0, "unexpected_valid", 1, 0);
      else check(cyc - exp_q[0].acc == LAT, "latency", cyc - exp_q[0].acc, LAT);
    end
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_result", 1, 0);
      end else begin
        x = exp_q.pop_front();
        check(out_err == x.e, "err", int'(out_err), int'(x.e));
        if (x.e) begin
          check(out_sin == 16'sd0, "err_sin", int'(out_sin), 0);
          check(out_cos == 16'sd0, "err_cos", int'(out_cos), 0);
        end else begin
          check(iabs(int'(out_sin) - x.s) <= TOL, "sin", int'(out_sin), x.s);
          check(iabs(int'(out_cos) - x.c) <= TOL, "cos", int'(out_cos), x.c);
        end
      end
      last_hs <= cyc + 1;
    end
    prev_valid <= out_valid;
  end

  task automatic send(input logic [19:0] a);
    int s, c, n;
    bit e, rdy;
    n = 0;
    in_angle = a;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 300);
    in_valid = 1'b0;
    if (!rdy) begin
      check(1'b0, "accept_timeout", 0, 1);
    end else begin
      model(int'(a), s, c, e);
      exp_q.push_back('{s, c, e, cyc});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int dir[8];
    int n, s0, c0, e0;
    logic [19:0] a;

    reset = 1'b1;
    in_valid = 1'b0;
    in_angle = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(in_ready == 1'b1, "rst_in_ready", int'(in_ready), 1);
    check(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
    check(out_sin == 16'sd0 && out_cos == 16'sd0, "rst_outputs", int'(out_sin), 0);
    check(out_err == 1'b0, "rst_err", int'(out_err), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    dir = '{0, 34315, 240203, 446091, 823552, PI2, 2 * PI2, 3 * PI2};
    foreach (dir[i]) begin
      send(20'(dir[i]));
      drain();
    end

    // Backpressure: result must hold and a second angle must wait.
    out_ready = 1'b0;
    send(20'd34315);
    in_angle = 20'd240203;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    check(out_valid == 1'b1, "stall_valid_timeout", int'(out_valid), 1);
    s0 = int'(out_sin);
    c0 = int'(out_cos);
    e0 = int'(out_err);
    repeat (10) begin
      @(negedge clk);
      check(int'(out_sin) == s0 && int'(out_cos) == c0, "stall_hold", int'(out_sin), s0);
      check(int'(out_err) == e0 && out_valid, "stall_err_valid", int'(out_err), e0);
      check(in_ready == 1'b0, "stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(20'd240203);
    check(exp_q.size() == 1 && exp_q[exp_q.size() - 1].acc == last_hs + 1, "accept_after_hs",
          exp_q[exp_q.size() - 1].acc, last_hs + 1);
    drain();

    // Reset in the middle of the iterations discards the angle.
    send(20'd34315);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check(out_valid == 1'b0, "midrst_out_valid", int'(out_valid), 0);
    check(in_ready == 1'b1, "midrst_in_ready", int'(in_ready), 1);
    check(out_sin == 16'sd0 && out_cos == 16'sd0, "midrst_outputs", int'(out_cos), 0);
    @(posedge clk);
    #1;
    send(20'd34315);
    drain();

    repeat (40) begin
      if ($urandom_range(0, 3) == 0) a = 20'($urandom_range(823552, 1048575));
      else a = 20'($urandom_range(0, 823551));
      send(a);
    end
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
